jtbubl_objdraw: RTL and testbench

JTBUBL_OBJDRAW -- requirements
Module: jtbubl_objdraw

---
 rtl/jtbubl_obj_pkg.sv | 23 ++
 rtl/jtbubl_objdraw_pxl.sv | 34 +++
 rtl/jtbubl_objdraw.sv | 162 ++++++++++++++++
 tb/tb_jtbubl_objdraw.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_obj_pkg.sv
// Shared definitions for the object line drawer: FSM encoding and the
// 4bpp plane-unpack pixel extraction used by the pixel sub-module.
package jtbubl_obj_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;

  localparam logic [3:0] PEN_TRANSP = 4'hF;

  // Pixels 0..3 live in the low half-word, 4..7 in the high half-word;
  // the four planes of a pixel are 4 bits apart and stored inverted.
  function automatic logic [3:0] obj_pen(input logic [31:0] d,
                                         input logic [2:0]  k,
                                         input logic        hflip);
    logic [2:0] kk;
    logic [4:0] a;
    kk = hflip ? ~k : k;
    a  = kk[2] ? ({2'b00, kk} + 5'd12) : {2'b00, kk};
    obj_pen = ~{d[a], d[a + 5'd4], d[a + 5'd8], d[a + 5'd12]};
  endfunction

endpackage

// File: rtl/jtbubl_objdraw_pxl.sv
// Holds one fetched ROM word and steps through its eight pixels,
// presenting the current pen; last flags the eighth pixel.
module jtbubl_objdraw_pxl
  import jtbubl_obj_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic        hflip,
  input  logic [31:0] data,
  output logic [3:0]  pen,
  output logic        last
);

  logic [31:0] word;
  logic [2:0]  left;

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      left <= 3'd7;
    end else if (load) begin
      word <= data;
      left <= 3'd7;
    end else if (adv) begin
      left <= left - 3'd1;
    end
  end

  assign pen  = obj_pen(word, 3'd7 - left, hflip);
  assign last = (left == 3'd0);

endmodule

// File: rtl/jtbubl_objdraw.sv
// Object line drawer: fetches one or two 32-bit tile words from ROM and
// writes their pixels into the line buffer. Build option:
// JTBUBL_OBJDRAW_TRANSP_EN skips writes of pen 4'hF.
//
// state | meaning
// IDLE  | waiting for a draw request
// FETCH | rom_cs high, waiting for rom_ok past the stale-data cycle
// DRAW  | writing eight pixels of the captured word
module jtbubl_objdraw
  import jtbubl_obj_pkg::*;
#(
  parameter int TILEW = 8,
  parameter int CW    = 10,
  parameter int PALW  = 4,
  parameter int BANKW = 4,
  parameter int AW    = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        abort,
  input  logic                        draw,
  input  logic [CW-1:0]               code,
  input  logic [PALW-1:0]             pal,
  input  logic                        hflip,
  input  logic                        vflip,
  input  logic [$clog2(TILEW)-1:0]    row,
  input  logic [BANKW-1:0]            bank,
  input  logic [AW-1:0]               hpos,
  output logic                        busy,
  output logic [BANKW+CW+$clog2(TILEW)+$clog2(TILEW/8):0] rom_addr,
  output logic                        rom_cs,
  input  logic                        rom_ok,
  input  logic [31:0]                 rom_data,
  output logic [AW-1:0]               buf_addr,
  output logic [PALW+3:0]             buf_data,
  output logic                        buf_we
);

  localparam int RW  = $clog2(TILEW);
  localparam int RAW = BANKW + CW + RW + $clog2(TILEW/8) + 1;

  logic [1:0]       state;
  logic             guard;
  logic             word_idx;
  logic [CW-1:0]    code_r;
  logic [PALW-1:0]  pal_r;
  logic             hflip_r;
  logic [RW-1:0]    row_r;
  logic [BANKW-1:0] bank_r;

  logic [RAW-1:0]   addr_first;
  logic [RAW-1:0]   addr_second;
  logic             more_words;
  logic             drawing;
  logic             pxl_load;
  logic             pxl_last;
  logic [3:0]       pen;

  generate
    if (TILEW == 16) begin : g_w16
      // wsel of the first word is 0 unless the tile is mirrored
      assign addr_first  = {bank, code, row ^ {RW{vflip}}, hflip, 1'b0};
      assign addr_second = {bank_r, code_r, row_r, ~hflip_r, 1'b0};
    end else begin : g_w8
      assign addr_first  = {bank, code, row ^ {RW{vflip}}, 1'b0};
      assign addr_second = {bank_r, code_r, row_r, 1'b0};
    end
  endgenerate

  assign more_words = (TILEW == 16) && !word_idx;
  assign drawing    = (state == ST_DRAW);
  assign pxl_load   = (state == ST_FETCH) && !guard && rom_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      guard    <= 1'b0;
      word_idx <= 1'b0;
      code_r   <= '0;
      pal_r    <= '0;
      hflip_r  <= 1'b0;
      row_r    <= '0;
      bank_r   <= '0;
      buf_addr <= '0;
    end else if (abort) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      rom_cs <= 1'b0;
      guard  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (draw && !busy) begin
            code_r   <= code;
            pal_r    <= pal;
            hflip_r  <= hflip;
            row_r    <= row ^ {RW{vflip}};
            bank_r   <= bank;
            buf_addr <= hpos;
            rom_addr <= addr_first;
            word_idx <= 1'b0;
            guard    <= 1'b1;
            rom_cs   <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (guard) begin
            guard <= 1'b0;
          end else if (rom_ok) begin
            rom_cs <= 1'b0;
            state  <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          buf_addr <= buf_addr + AW'(1);
          if (pxl_last) begin
            if (more_words) begin
              word_idx <= 1'b1;
              rom_addr <= addr_second;
              guard    <= 1'b1;
              rom_cs   <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rom_cs <= 1'b0;
        end
      endcase
    end
  end

  jtbubl_objdraw_pxl u_pxl (
    .clk   (clk),
    .rst   (rst),
    .load  (pxl_load),
    .adv   (drawing),
    .hflip (hflip_r),
    .data  (rom_data),
    .pen   (pen),
    .last  (pxl_last)
  );

`ifdef JTBUBL_OBJDRAW_TRANSP_EN
  assign buf_we = drawing && (pen != PEN_TRANSP);
`else
  assign buf_we = drawing;
`endif

  assign buf_data = drawing ? {pal_r, pen} : '0;

endmodule

// File: tb/tb_jtbubl_objdraw.sv
// Directed bench for jtbubl_objdraw: one TILEW=8 and one TILEW=16 instance.
module tb_jtbubl_objdraw;

  logic        clk = 1'b0;
  logic        rst, abort;
  logic        draw8, draw16;
  logic [9:0]  code;
  logic [3:0]  pal;
  logic        hflip, vflip;
  logic [2:0]  row8;
  logic [3:0]  row16;
  logic [3:0]  bank;
  logic [8:0]  hpos;
  logic        rom_ok8, rom_ok16;
  logic [31:0] rom_data;

  logic        busy8, rom_cs8, buf_we8;
  logic [17:0] rom_addr8;
  logic [8:0]  buf_addr8;
  logic [7:0]  buf_data8;
  logic        busy16, rom_cs16, buf_we16;
  logic [19:0] rom_addr16;
  logic [8:0]  buf_addr16;
  logic [7:0]  buf_data16;

  int n_tests = 0;
  int n_fail  = 0;
  int wr8 = 0;
  int wr16 = 0;
  int base;
  logic [8:0] ea;

  // pens of unflipped pixels 0..7 are 0..7 for this word
  localparam logic [31:0] WORD = 32'h530F53FF;
`ifdef JTBUBL_OBJDRAW_TRANSP_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  always #5 clk = ~clk;

  jtbubl_objdraw #(.TILEW(8)) u8 (
    .clk(clk), .rst(rst), .abort(abort), .draw(draw8), .code(code), .pal(pal),
    .hflip(hflip), .vflip(vflip), .row(row8), .bank(bank), .hpos(hpos),
    .busy(busy8), .rom_addr(rom_addr8), .rom_cs(rom_cs8), .rom_ok(rom_ok8),
    .rom_data(rom_data), .buf_addr(buf_addr8), .buf_data(buf_data8), .buf_we(buf_we8)
  );

  jtbubl_objdraw #(.TILEW(16)) u16 (
    .clk(clk), .rst(rst), .abort(abort), .draw(draw16), .code(code), .pal(pal),
    .hflip(hflip), .vflip(vflip), .row(row16), .bank(bank), .hpos(hpos),
    .busy(busy16), .rom_addr(rom_addr16), .rom_cs(rom_cs16), .rom_ok(rom_ok16),
    .rom_data(rom_data), .buf_addr(buf_addr16), .buf_data(buf_data16), .buf_we(buf_we16)
  );

  always @(posedge clk) begin
    if (buf_we8)  wr8++;
    if (buf_we16) wr16++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_we8(input string tag);
    int n = 0;
    while (buf_we8 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(tag, buf_we8, 1);
  endtask

  task automatic wait_we16(input string tag);
    int n = 0;
    while (buf_we16 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(tag, buf_we16, 1);
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; draw8 = 1'b0; draw16 = 1'b0;
    code = 10'h123; pal = 4'hA; hflip = 1'b0; vflip = 1'b0;
    row8 = 3'd5; row16 = 4'd5; bank = 4'd2; hpos = 9'h010;
    rom_ok8 = 1'b0; rom_ok16 = 1'b0; rom_data = WORD;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_rom_cs", rom_cs8, 0);
    chk("rst_buf_we", buf_we8, 0);
    chk("rst_buf_addr", buf_addr8, 0);
    chk("rst_buf_data", buf_data8, 0);
    chk("rst_rom_addr", rom_addr8, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic object, rom_ok three cycles after acceptance
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0;
    chk("t1_busy", busy8, 1);
    chk("t1_rom_cs", rom_cs8, 1);
    chk("t1_rom_addr", rom_addr8, {4'd2, 10'h123, 3'd5, 1'b0});
    @(negedge clk);
    chk("t1_wait_cs", rom_cs8, 1);
    @(negedge clk);
    rom_ok8 = 1'b1;
    @(negedge clk);
    rom_ok8 = 1'b0;
    chk("t1_cs_drop", rom_cs8, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t1_we", buf_we8, 1);
      chk("t1_addr", buf_addr8, 9'h010 + 9'(i));
      chk("t1_data", buf_data8, {4'hA, 4'(i)});
      if (i == 7) begin
        chk("t1_busy_last", busy8, 1);
        draw8 = 1'b1;
      end
      @(negedge clk);
    end
    draw8 = 1'b0;
    chk("t1_busy_end", busy8, 0);
    chk("t1_we_end", buf_we8, 0);
    @(negedge clk);
    chk("t1_late_draw_busy", busy8, 0);
    chk("t1_late_draw_cs", rom_cs8, 0);

    // both flips: row field inverted, pens reversed
    hflip = 1'b1; vflip = 1'b1;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0;
    chk("t2_rom_addr", rom_addr8, {4'd2, 10'h123, 3'd2, 1'b0});
    repeat (2) @(negedge clk);
    rom_ok8 = 1'b1;
    @(negedge clk);
    rom_ok8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_addr", buf_addr8, 9'h010 + 9'(i));
      chk("t2_data", buf_data8, {4'hA, 4'(7 - i)});
      @(negedge clk);
    end
    chk("t2_busy_end", busy8, 0);
    hflip = 1'b0; vflip = 1'b0;

    // rom_ok high from the start; stale data must not be captured
    base = wr8;
    hpos = 9'h1F8;
    rom_data = 32'hFFFFFFFF;
    draw8 = 1'b1; rom_ok8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0;
    chk("t3_busy", busy8, 1);
    @(negedge clk);
    chk("t3_guard_cs", rom_cs8, 1);
    chk("t3_guard_we", buf_we8, 0);
    rom_data = WORD;
    hpos = 9'h050;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0; rom_ok8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_addr", buf_addr8, 9'h1F8 + 9'(i));
      chk("t3_data", buf_data8, {4'hA, 4'(i)});
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("t3_no_second_busy", busy8, 0);
    chk("t3_write_count", wr8 - base, 8);

    // abort in the fourth DRAW cycle
    base = wr8;
    hpos = 9'h020;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0; rom_ok8 = 1'b1;
    wait_we8("t4_wait_draw");
    rom_ok8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_addr4", buf_addr8, 9'h023);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_we", buf_we8, 0);
    chk("t4_busy", busy8, 0);
    chk("t4_cs", rom_cs8, 0);
    repeat (6) @(negedge clk);
    chk("t4_write_count", wr8 - base, 4);
    hpos = 9'h030;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0;
    chk("t4_redraw_busy", busy8, 1);
    rom_ok8 = 1'b1;
    wait_we8("t4_redraw_wait");
    rom_ok8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_redraw_addr", buf_addr8, 9'h030 + 9'(i));
      @(negedge clk);
    end
    chk("t4_redraw_busy_end", busy8, 0);

    // all-zero word decodes to pen F on every pixel
    base = wr8;
    hpos = 9'h040;
    rom_data = 32'h0;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0; rom_ok8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rom_ok8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t5_busy", busy8, 1);
      chk("t5_we", buf_we8, TRANSP ? 0 : 1);
      if (!TRANSP) chk("t5_data", buf_data8, 8'hAF);
      @(negedge clk);
    end
    chk("t5_busy_end", busy8, 0);
    chk("t5_write_count", wr8 - base, TRANSP ? 0 : 8);
    rom_data = WORD;

    // 16-wide tile crossing the end of the line buffer
    base = wr16;
    hpos = 9'h1FC;
    draw16 = 1'b1;
    @(negedge clk);
    draw16 = 1'b0;
    chk("t6_busy", busy16, 1);
    chk("t6_cs0", rom_cs16, 1);
    chk("t6_addr_w0", rom_addr16, {4'd2, 10'h123, 4'd5, 1'b0, 1'b0});
    rom_ok16 = 1'b1;
    ea = 9'h1FC;
    for (int w = 0; w < 2; w++) begin
      wait_we16("t6_wait_word");
      for (int i = 0; i < 8; i++) begin
        chk("t6_we", buf_we16, 1);
        chk("t6_addr", buf_addr16, ea);
        chk("t6_data", buf_data16, {4'hA, 4'(i)});
        chk("t6_cs_in_draw", rom_cs16, 0);
        ea = ea + 9'd1;
        @(negedge clk);
      end
      if (w == 0) begin
        chk("t6_gap_we", buf_we16, 0);
        chk("t6_cs1", rom_cs16, 1);
        chk("t6_addr_w1", rom_addr16, {4'd2, 10'h123, 4'd5, 1'b1, 1'b0});
      end
    end
    rom_ok16 = 1'b0;
    chk("t6_busy_end", busy16, 0);
    chk("t6_write_count", wr16 - base, 16);

    // reset in the middle of a DRAW discards the object
    hpos = 9'h060;
    draw8 = 1'b1;
    @(negedge clk);
    draw8 = 1'b0; rom_ok8 = 1'b1;
    wait_we8("t7_wait_draw");
    rom_ok8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_busy", busy8, 0);
    chk("t7_we", buf_we8, 0);
    chk("t7_buf_addr", buf_addr8, 0);
    chk("t7_rom_addr", rom_addr8, 0);
    base = wr8;
    repeat (6) @(negedge clk);
    chk("t7_no_writes", wr8 - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
